// File: rtl/exec_ctrl_unit_pkg.sv
// Shared constants and types for the decode/execute/interrupt slice of the
// single-cycle MIPS CPU: ALU op codes, opcode/funct/mf encodings and the
// packed control-flag bundle produced by the controller.
package exec_ctrl_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned IRQ_W   = 3;

    // ALU operation select
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_MUL  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_DIV  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd9;
    localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd10;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd11;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd12;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ERET    = 6'h18;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // CP0 sub-ops (instruction[25:21])
    localparam logic [4:0] MF_MFC0 = 5'h00;
    localparam logic [4:0] MF_MTC0 = 5'h04;
    localparam logic [4:0] MF_ERET = 5'h10;

    typedef struct packed {
        logic rf_dst;
        logic rf_we;
        logic branch;
        logic jump;
        logic mem_we;
        logic mem_to_reg;
        logic alu_src;
        logic shift;
        logic branch_eq;
        logic branch_leq;
        logic jump_reg;
        logic jal;
        logic usign;
        logic sys;
        logic shift_var;
        logic load_imm;
        logic store_half;
        logic exce_ret;
        logic mfc0;
        logic mtc0;
    } ctrl_flags_t;

endpackage

// File: rtl/exec_ctrl_unit_alu.sv
// 32-bit combinational ALU.
// Ports: aluop (operation select), x/y (operands), r1 (primary result),
// r2 (mul high word / div remainder, else 0), eq (x == y).
module alu
    import exec_ctrl_unit_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [XLEN-1:0]    x,
    input  logic [XLEN-1:0]    y,
    output logic [XLEN-1:0]    r1,
    output logic [XLEN-1:0]    r2,
    output logic               eq
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   ax, ay, uq, ur;
    logic [4:0]        shamt;

    assign shamt = y[4:0];
    // Low 64 bits of the sign-extended product equal the signed product
    assign prod  = {{XLEN{x[XLEN-1]}}, x} * {{XLEN{y[XLEN-1]}}, y};

    // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow case
    assign ax = x[XLEN-1] ? -x : x;
    assign ay = y[XLEN-1] ? -y : y;
    assign uq = (ay == '0) ? '0 : ax / ay;
    assign ur = (ay == '0) ? '0 : ax % ay;

    assign eq = (x == y);

    // Operation select
    always_comb begin
        r1 = '0;
        r2 = '0;
        case (aluop)
            ALU_SLL:  r1 = x << shamt;
            ALU_SRA:  r1 = $unsigned($signed(x) >>> shamt);
            ALU_SRL:  r1 = x >> shamt;
            ALU_MUL:  {r2, r1} = prod;
            ALU_DIV: begin
                if (y == '0) begin
                    r1 = '1;
                    r2 = x;
                end else begin
                    r1 = (x[XLEN-1] ^ y[XLEN-1]) ? -uq : uq;
                    r2 = x[XLEN-1] ? -ur : ur;
                end
            end
            ALU_ADD:  r1 = x + y;
            ALU_SUB:  r1 = x - y;
            ALU_AND:  r1 = x & y;
            ALU_OR:   r1 = x | y;
            ALU_XOR:  r1 = x ^ y;
            ALU_NOR:  r1 = ~(x | y);
            ALU_SLT:  r1 = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            ALU_SLTU: r1 = {{(XLEN-1){1'b0}}, (x < y)};
            default: begin
                r1 = '0;
                r2 = '0;
            end
        endcase
    end

endmodule

// File: rtl/exec_ctrl_unit_controller.sv
// Combinational instruction decoder.
// Ports: op/funct/mf (instruction fields), aluop (ALU select),
// flags (datapath control bundle). Undefined encodings decode to all zero.
module controller
    import exec_ctrl_unit_pkg::*;
(
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic [4:0]         mf,
    output logic [ALUOP_W-1:0] aluop,
    output ctrl_flags_t        flags
);

    // Decode table
    always_comb begin
        aluop = ALU_SLL;
        flags = '0;
        case (op)
            OP_RTYPE: begin
                flags.rf_dst = 1'b1;
                flags.rf_we  = 1'b1;
                case (funct)
                    FN_SLL:  begin aluop = ALU_SLL; flags.shift = 1'b1; end
                    FN_SRL:  begin aluop = ALU_SRL; flags.shift = 1'b1; end
                    FN_SRA:  begin aluop = ALU_SRA; flags.shift = 1'b1; end
                    FN_SLLV: begin aluop = ALU_SLL; flags.shift = 1'b1; flags.shift_var = 1'b1; end
                    FN_SRLV: begin aluop = ALU_SRL; flags.shift = 1'b1; flags.shift_var = 1'b1; end
                    FN_SRAV: begin aluop = ALU_SRA; flags.shift = 1'b1; flags.shift_var = 1'b1; end
                    FN_ADD, FN_ADDU: aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: aluop = ALU_SUB;
                    FN_AND:  aluop = ALU_AND;
                    FN_OR:   aluop = ALU_OR;
                    FN_XOR:  aluop = ALU_XOR;
                    FN_NOR:  aluop = ALU_NOR;
                    FN_SLT:  aluop = ALU_SLT;
                    FN_SLTU: begin aluop = ALU_SLTU; flags.usign = 1'b1; end
                    FN_JR: begin
                        flags          = '0;
                        flags.jump_reg = 1'b1;
                    end
                    FN_SYSCALL: begin
                        flags     = '0;
                        flags.sys = 1'b1;
                    end
                    default: flags = '0;
                endcase
            end
            OP_J:    flags.jump = 1'b1;
            OP_JAL: begin
                flags.jump  = 1'b1;
                flags.jal   = 1'b1;
                flags.rf_we = 1'b1;
            end
            OP_BEQ: begin
                aluop           = ALU_SUB;
                flags.branch    = 1'b1;
                flags.branch_eq = 1'b1;
            end
            OP_BNE: begin
                aluop        = ALU_SUB;
                flags.branch = 1'b1;
            end
            OP_BLEZ: begin
                flags.branch     = 1'b1;
                flags.branch_leq = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                aluop         = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
                flags.alu_src = 1'b1;
                flags.rf_we   = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                aluop         = (op == OP_ANDI) ? ALU_AND :
                                (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
                flags.alu_src = 1'b1;
                flags.rf_we   = 1'b1;
                flags.usign   = 1'b1;
            end
            OP_LUI: begin
                flags.load_imm = 1'b1;
                flags.rf_we    = 1'b1;
            end
            OP_LW: begin
                aluop            = ALU_ADD;
                flags.alu_src    = 1'b1;
                flags.mem_to_reg = 1'b1;
                flags.rf_we      = 1'b1;
            end
            OP_SW, OP_SH: begin
                aluop            = ALU_ADD;
                flags.alu_src    = 1'b1;
                flags.mem_we     = 1'b1;
                flags.store_half = (op == OP_SH);
            end
            OP_COP0: begin
                if (mf == MF_MFC0) begin
                    flags.mfc0  = 1'b1;
                    flags.rf_we = 1'b1;
                end else if (mf == MF_MTC0) begin
                    flags.mtc0 = 1'b1;
                end else if (mf == MF_ERET && funct == FN_ERET) begin
                    flags.exce_ret = 1'b1;
                end
            end
            default: begin
                aluop = ALU_SLL;
                flags = '0;
            end
        endcase
    end

endmodule

// File: rtl/exec_ctrl_unit_irq.sv
// Interrupt edge detection, pending latch and priority arbitration.
// Ports: clk, rst_n, irq_in (raw lines), irq_mask (1 = blocked),
// irq_disable (global block), irq_grant (one-hot, bit 2 highest priority).
module interrupt_driver
    import exec_ctrl_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IRQ_W-1:0] irq_in,
    input  logic [IRQ_W-1:0] irq_mask,
    input  logic             irq_disable,
    output logic [IRQ_W-1:0] irq_grant
);

    logic [IRQ_W-1:0] irq_prev;
    logic [IRQ_W-1:0] pending;
    logic [IRQ_W-1:0] eligible;

    assign eligible = irq_disable ? '0 : (pending & ~irq_mask);

    // Fixed priority pick; grant follows pending/mask/disable without delay
    always_comb begin
        irq_grant = '0;
        if (eligible[2])      irq_grant = 3'b100;
        else if (eligible[1]) irq_grant = 3'b010;
        else if (eligible[0]) irq_grant = 3'b001;
    end

    // Served bits clear; a fresh rising edge on the same cycle re-arms (set wins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= irq_in;
            pending  <= (pending & ~irq_grant) | (irq_in & ~irq_prev);
        end
    end

endmodule

// File: rtl/exec_ctrl_unit.sv
// Decode/execute core with interrupt arbitration for the single-cycle CPU.
// Ports: clk, rst_n; op/funct/mf instruction fields; alu_x/alu_y operands;
// irq_in/irq_mask/irq_disable interrupt inputs; aluop and control flags;
// alu_r1/alu_r2/alu_eq ALU results; irq_grant one-hot request.
module exec_ctrl_unit
    import exec_ctrl_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [4:0]  mf,
    input  logic [31:0] alu_x,
    input  logic [31:0] alu_y,
    input  logic [2:0]  irq_in,
    input  logic [2:0]  irq_mask,
    input  logic        irq_disable,
    output logic [3:0]  aluop,
    output logic        rf_dst,
    output logic        rf_we,
    output logic        branch,
    output logic        jump,
    output logic        mem_we,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic        shift,
    output logic        branch_eq,
    output logic        branch_leq,
    output logic        jump_reg,
    output logic        jal,
    output logic        usign,
    output logic        sys,
    output logic        shift_var,
    output logic        load_imm,
    output logic        store_half,
    output logic        exce_ret,
    output logic        mfc0,
    output logic        mtc0,
    output logic [31:0] alu_r1,
    output logic [31:0] alu_r2,
    output logic        alu_eq,
    output logic [2:0]  irq_grant
);

    ctrl_flags_t flags;

    controller u_controller (
        .op    (op),
        .funct (funct),
        .mf    (mf),
        .aluop (aluop),
        .flags (flags)
    );

    alu u_alu (
        .aluop (aluop),
        .x     (alu_x),
        .y     (alu_y),
        .r1    (alu_r1),
        .r2    (alu_r2),
        .eq    (alu_eq)
    );

    interrupt_driver u_irq (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .irq_mask    (irq_mask),
        .irq_disable (irq_disable),
        .irq_grant   (irq_grant)
    );

    assign {rf_dst, rf_we, branch, jump, mem_we, mem_to_reg, alu_src, shift,
            branch_eq, branch_leq, jump_reg, jal, usign, sys, shift_var,
            load_imm, store_half, exce_ret, mfc0, mtc0} = flags;

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Self-checking bench for exec_ctrl_unit: directed and random ALU checks,
// a full decode sweep against a table model, and cycle-level interrupt checks.
module tb_exec_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op, funct;
    logic [4:0]  mf;
    logic [31:0] alu_x, alu_y;
    logic [2:0]  irq_in, irq_mask;
    logic        irq_disable;
    logic [3:0]  aluop;
    logic        rf_dst, rf_we, branch, jump, mem_we, mem_to_reg, alu_src, shift;
    logic        branch_eq, branch_leq, jump_reg, jal, usign, sys, shift_var;
    logic        load_imm, store_half, exce_ret, mfc0, mtc0;
    logic [31:0] alu_r1, alu_r2;
    logic        alu_eq;
    logic [2:0]  irq_grant;

    // Standalone ALU so mul/div (not reachable through decode) can be exercised
    logic [3:0]  a_op;
    logic [31:0] a_x, a_y, a_r1, a_r2;
    logic        a_eq;

    int checks   = 0;
    int failures = 0;

    bit [2:0] m_pend;
    bit [2:0] m_prev;

    logic [19:0] flags_obs;
    assign flags_obs = {rf_dst, rf_we, branch, jump, mem_we, mem_to_reg, alu_src, shift,
                        branch_eq, branch_leq, jump_reg, jal, usign, sys, shift_var,
                        load_imm, store_half, exce_ret, mfc0, mtc0};

    localparam logic [19:0] RD  = 20'h80000, WE = 20'h40000, BR = 20'h20000, JP = 20'h10000;
    localparam logic [19:0] MW  = 20'h08000, MR = 20'h04000, AS = 20'h02000, SH = 20'h01000;
    localparam logic [19:0] BE  = 20'h00800, BL = 20'h00400, JR = 20'h00200, JL = 20'h00100;
    localparam logic [19:0] US  = 20'h00080, SY = 20'h00040, SV = 20'h00020, LI = 20'h00010;
    localparam logic [19:0] SHW = 20'h00008, ER = 20'h00004, MFF = 20'h00002, MT = 20'h00001;

    exec_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mf(mf),
        .alu_x(alu_x), .alu_y(alu_y), .irq_in(irq_in), .irq_mask(irq_mask),
        .irq_disable(irq_disable), .aluop(aluop), .rf_dst(rf_dst), .rf_we(rf_we),
        .branch(branch), .jump(jump), .mem_we(mem_we), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .shift(shift), .branch_eq(branch_eq), .branch_leq(branch_leq),
        .jump_reg(jump_reg), .jal(jal), .usign(usign), .sys(sys), .shift_var(shift_var),
        .load_imm(load_imm), .store_half(store_half), .exce_ret(exce_ret), .mfc0(mfc0),
        .mtc0(mtc0), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_eq(alu_eq), .irq_grant(irq_grant)
    );

    alu u_alu_only (.aluop(a_op), .x(a_x), .y(a_y), .r1(a_r1), .r2(a_r2), .eq(a_eq));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: {r2, r1} computed with 64-bit signed arithmetic
    function automatic logic [63:0] alu_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        int sh;
        logic [31:0] r1, r2;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y[4:0]);
        r1 = 32'h0;
        r2 = 32'h0;
        case (o)
            4'd0:  r1 = x << sh;
            4'd1:  r1 = 32'(sx >> sh);
            4'd2:  r1 = x >> sh;
            4'd3:  begin p = sx * sy; r1 = p[31:0]; r2 = p[63:32]; end
            4'd4:  begin
                if (y == 32'h0) begin r1 = 32'hFFFF_FFFF; r2 = x; end
                else begin q = sx / sy; r = sx % sy; r1 = q[31:0]; r2 = r[31:0]; end
            end
            4'd5:  r1 = x + y;
            4'd6:  r1 = x - y;
            4'd7:  r1 = x & y;
            4'd8:  r1 = x | y;
            4'd9:  r1 = x ^ y;
            4'd10: r1 = ~(x | y);
            4'd11: r1 = (sx < sy) ? 32'd1 : 32'd0;
            4'd12: r1 = (x < y) ? 32'd1 : 32'd0;
            default: ;
        endcase
        return {r2, r1};
    endfunction

    // Reference decode table: {aluop, flags}
    function automatic logic [23:0] ctrl_model(input logic [5:0] o, input logic [5:0] f, input logic [4:0] m);
        logic [3:0]  a;
        logic [19:0] fl;
        a  = 4'd0;
        fl = 20'h0;
        case (o)
            6'h00: case (f)
                6'h00: begin a = 4'd0;  fl = RD | WE | SH; end
                6'h02: begin a = 4'd2;  fl = RD | WE | SH; end
                6'h03: begin a = 4'd1;  fl = RD | WE | SH; end
                6'h04: begin a = 4'd0;  fl = RD | WE | SH | SV; end
                6'h06: begin a = 4'd2;  fl = RD | WE | SH | SV; end
                6'h07: begin a = 4'd1;  fl = RD | WE | SH | SV; end
                6'h20, 6'h21: begin a = 4'd5; fl = RD | WE; end
                6'h22, 6'h23: begin a = 4'd6; fl = RD | WE; end
                6'h24: begin a = 4'd7;  fl = RD | WE; end
                6'h25: begin a = 4'd8;  fl = RD | WE; end
                6'h26: begin a = 4'd9;  fl = RD | WE; end
                6'h27: begin a = 4'd10; fl = RD | WE; end
                6'h2A: begin a = 4'd11; fl = RD | WE; end
                6'h2B: begin a = 4'd12; fl = RD | WE | US; end
                6'h08: fl = JR;
                6'h0C: fl = SY;
                default: ;
            endcase
            6'h02: fl = JP;
            6'h03: fl = JP | JL | WE;
            6'h04: begin a = 4'd6; fl = BR | BE; end
            6'h05: begin a = 4'd6; fl = BR; end
            6'h06: fl = BR | BL;
            6'h08, 6'h09: begin a = 4'd5; fl = AS | WE; end
            6'h0A: begin a = 4'd11; fl = AS | WE; end
            6'h0C: begin a = 4'd7; fl = AS | WE | US; end
            6'h0D: begin a = 4'd8; fl = AS | WE | US; end
            6'h0E: begin a = 4'd9; fl = AS | WE | US; end
            6'h0F: fl = LI | WE;
            6'h23: begin a = 4'd5; fl = AS | MR | WE; end
            6'h2B: begin a = 4'd5; fl = AS | MW; end
            6'h29: begin a = 4'd5; fl = AS | MW | SHW; end
            6'h10: begin
                if (m == 5'h00)                    fl = MFF | WE;
                else if (m == 5'h04)               fl = MT;
                else if (m == 5'h10 && f == 6'h18) fl = ER;
            end
            default: ;
        endcase
        return {a, fl};
    endfunction

    // Interrupt model: highest eligible pending line wins
    function automatic logic [2:0] irq_model_grant(input logic [2:0] mask, input logic dis);
        if (dis) return 3'b000;
        for (int i = 2; i >= 0; i--)
            if (m_pend[i] && !mask[i]) return 3'(1 << i);
        return 3'b000;
    endfunction

    task automatic alu_dir(input string tag, input logic [3:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] e1, input logic [31:0] e2);
        a_op = o; a_x = x; a_y = y;
        #1;
        check({tag, "_r1"}, 64'(a_r1), 64'(e1));
        check({tag, "_r2"}, 64'(a_r2), 64'(e2));
    endtask

    // One clock of interrupt traffic; called 1 time unit after a rising edge
    task automatic irq_cycle(input string tag, input logic [2:0] in, input logic [2:0] mask,
                             input logic dis, input bit use_lit, input logic [2:0] lit);
        logic [2:0] g;
        irq_in = in; irq_mask = mask; irq_disable = dis;
        #3;
        g = irq_model_grant(mask, dis);
        check({tag, "_model"}, 64'(irq_grant), 64'(g));
        if (use_lit) check({tag, "_lit"}, 64'(irq_grant), 64'(lit));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (g[i]) m_pend[i] = 1'b0;
            if (in[i] && !m_prev[i]) m_pend[i] = 1'b1;
        end
        m_prev = in;
        #1;
    endtask

    initial begin
        logic [23:0] exp_c;
        logic [63:0] exp_a;
        logic [5:0]  fl_list [0:17];
        fl_list = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                    6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h0C};

        rst_n = 1'b0; op = 6'h0; funct = 6'h0; mf = 5'h0; alu_x = 32'h0; alu_y = 32'h0;
        irq_in = 3'b0; irq_mask = 3'b0; irq_disable = 1'b0;
        a_op = 4'd0; a_x = 32'h0; a_y = 32'h0;
        m_pend = 3'b0; m_prev = 3'b0;
        #3;
        check("reset_grant", 64'(irq_grant), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed ALU cases
        alu_dir("sra",    4'd1,  32'h8000_0000, 32'd4, 32'hF800_0000, 32'h0);
        alu_dir("srl",    4'd2,  32'h8000_0000, 32'd4, 32'h0800_0000, 32'h0);
        alu_dir("sltu",   4'd12, 32'h8000_0000, 32'd1, 32'h0,         32'h0);
        alu_dir("slt",    4'd11, 32'h8000_0000, 32'd1, 32'h1,         32'h0);
        alu_dir("mul",    4'd3,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        alu_dir("div",    4'd4,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1);
        alu_dir("div0",   4'd4,  32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678);
        alu_dir("divmin", 4'd4,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        alu_dir("op13",   4'd13, 32'h1234_5678, 32'h9, 32'h0, 32'h0);
        a_x = 32'hDEAD_BEEF; a_y = 32'hDEAD_BEEF; #1;
        check("eq_true", 64'(a_eq), 64'h1);
        a_y = 32'hDEAD_BEEE; #1;
        check("eq_false", 64'(a_eq), 64'h0);

        // Random ALU against the reference
        for (int i = 0; i < 300; i++) begin
            a_op = 4'($urandom);
            a_x  = $urandom;
            a_y  = (i % 7 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            #1;
            exp_a = alu_model(a_op, a_x, a_y);
            check("alu_rand_r1", 64'(a_r1), 64'(exp_a[31:0]));
            check("alu_rand_r2", 64'(a_r2), 64'(exp_a[63:32]));
            check("alu_rand_eq", 64'(a_eq), 64'(a_x == a_y));
        end

        // Directed decode corners
        op = 6'h3F; funct = 6'h3F; mf = 5'h1F; #1;
        check("op3f", 64'({aluop, flags_obs}), 64'h0);
        op = 6'h00; funct = 6'h0C; mf = 5'h00; #1;
        check("syscall", 64'({aluop, flags_obs}), 64'({4'd0, SY}));

        // Full decode sweep; mf swept exhaustively for the CP0 opcode
        for (int o = 0; o < 64; o++) begin
            for (int f = 0; f < 64; f++) begin
                for (int m = 0; m < ((o == 16) ? 32 : 1); m++) begin
                    op = 6'(o); funct = 6'(f);
                    mf = (o == 16) ? 5'(m) : 5'($urandom);
                    #1;
                    exp_c = ctrl_model(op, funct, mf);
                    check("decode", 64'({aluop, flags_obs}), 64'(exp_c));
                end
            end
        end

        // Full path through decode into the ALU
        for (int i = 0; i < 150; i++) begin
            op = 6'h00; funct = fl_list[$urandom_range(0, 15)]; mf = 5'h0;
            alu_x = $urandom; alu_y = $urandom;
            #1;
            exp_c = ctrl_model(op, funct, mf);
            exp_a = alu_model(exp_c[23:20], alu_x, alu_y);
            check("path_r1", 64'(alu_r1), 64'(exp_a[31:0]));
            check("path_r2", 64'(alu_r2), 64'(exp_a[63:32]));
            check("path_eq", 64'(alu_eq), 64'(alu_x == alu_y));
        end

        // Interrupt directed sequence
        @(posedge clk); #1;
        irq_cycle("pulse",    3'b011, 3'b000, 1'b0, 1'b1, 3'b000);
        irq_cycle("first",    3'b000, 3'b000, 1'b0, 1'b1, 3'b010);
        irq_cycle("disabled", 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
        irq_cycle("second",   3'b000, 3'b000, 1'b0, 1'b1, 3'b001);
        irq_cycle("drained",  3'b000, 3'b000, 1'b0, 1'b1, 3'b000);
        irq_cycle("mpulse",   3'b100, 3'b100, 1'b0, 1'b1, 3'b000);
        irq_cycle("masked",   3'b000, 3'b100, 1'b0, 1'b1, 3'b000);
        irq_cycle("unmasked", 3'b000, 3'b000, 1'b0, 1'b1, 3'b100);
        irq_cycle("served",   3'b000, 3'b000, 1'b0, 1'b1, 3'b000);
        irq_cycle("lvl0",     3'b100, 3'b000, 1'b0, 1'b1, 3'b000);
        irq_cycle("lvl1",     3'b100, 3'b000, 1'b0, 1'b1, 3'b100);
        irq_cycle("lvl2",     3'b100, 3'b000, 1'b0, 1'b1, 3'b000);
        irq_cycle("lvl3",     3'b000, 3'b000, 1'b0, 1'b1, 3'b000);
        irq_cycle("sw_set",   3'b100, 3'b000, 1'b1, 1'b1, 3'b000);
        irq_cycle("sw_low",   3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
        irq_cycle("sw_both",  3'b100, 3'b000, 1'b0, 1'b1, 3'b100);
        irq_cycle("sw_kept",  3'b000, 3'b000, 1'b0, 1'b1, 3'b100);
        irq_cycle("sw_done",  3'b000, 3'b000, 1'b0, 1'b1, 3'b000);

        // Asynchronous reset with a request pending
        irq_cycle("rst_set",  3'b100, 3'b000, 1'b1, 1'b1, 3'b000);
        irq_cycle("rst_hold", 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
        irq_disable = 1'b0; #1;
        check("rst_before", 64'(irq_grant), 64'h4);
        rst_n = 1'b0; #1;
        check("rst_now", 64'(irq_grant), 64'h0);
        m_pend = 3'b0; m_prev = 3'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        irq_cycle("post0", 3'b000, 3'b000, 1'b0, 1'b1, 3'b000);
        irq_cycle("post1", 3'b000, 3'b000, 1'b0, 1'b1, 3'b000);
        irq_cycle("post2", 3'b000, 3'b000, 1'b0, 1'b1, 3'b000);

        // Random interrupt traffic
        for (int i = 0; i < 300; i++) begin
            irq_cycle("irq_rand", 3'($urandom),
                      ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
                      ($urandom_range(0, 4) == 0), 1'b0, 3'b000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
